// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between pipeline writeback
// (highest priority) and an I/O requester. An accepted I/O write sits in a
// one-entry buffer until a cycle with no writeback request drains it.
//
// Optional feature macro: RF_ARB_STARVE_EN
//   defined   : after STARVE_LIMIT consecutive lost cycles the arbiter enters
//               FORCE and raises stall so the pipeline frees the port.
//   undefined : no FORCE state or wait counter; stall is tied low and the
//               buffer waits for a free cycle indefinitely.
//
// Ports
//   clock       single clock, rising-edge updates
//   reset       asynchronous, active-low reset
//   wb_en       writeback write request (highest priority)
//   wb_rd       writeback destination register
//   wb_data     writeback data
//   io_req      I/O write request, held until acked
//   io_rd       I/O destination register
//   io_data     I/O write data
//   io_ack      combinational ack; handshake on edge with io_req & io_ack
//   io_pending  buffered I/O write awaiting the port
//   stall       registered; pipeline holds wb_en low while high
//   rf_we       registered register-file write enable
//   rf_rd       registered register-file write address
//   rf_data     registered register-file write data
//
// state | meaning
// IDLE  | buffer empty, I/O requests accepted
// PEND  | buffer full, waiting for a cycle without writeback
// FORCE | buffer full, starvation limit hit, pipeline stalled (macro only)

module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        io_req,
  input  logic [4:0]  io_rd,
  input  logic [31:0] io_data,
  output logic        io_ack,
  output logic        io_pending,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("rf_write_arbiter: STARVE_LIMIT must be in 1..7");
  end

`ifdef RF_ARB_STARVE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FORCE = 2'd2} state_t;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1} state_t;
`endif

  state_t      state, state_next;
  logic        load, drain;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;

  assign io_ack     = io_req && (state == IDLE);
  assign io_pending = (state != IDLE);

`ifdef RF_ARB_STARVE_EN
  // Saturating so a protocol violation in FORCE cannot wrap the count.
  assign wait_cnt_inc = (wait_cnt == 3'd7) ? 3'd7 : wait_cnt + 3'd1;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drain      = 1'b0;
`ifdef RF_ARB_STARVE_EN
    wait_cnt_next = wait_cnt;
`endif
    case (state)
      IDLE: begin
        // Writes to r0 are acked and discarded.
        if (io_req && (io_rd != 5'd0)) begin
          load       = 1'b1;
          state_next = PEND;
`ifdef RF_ARB_STARVE_EN
          wait_cnt_next = 3'd0;
`endif
        end
      end
      PEND: begin
        if (!wb_en) begin
          drain      = 1'b1;
          state_next = IDLE;
`ifdef RF_ARB_STARVE_EN
          wait_cnt_next = 3'd0;
`endif
        end
`ifdef RF_ARB_STARVE_EN
        else begin
          // wb_en with wb_rd==0 still claims the port and counts as lost.
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc >= LIMIT) state_next = FORCE;
        end
`endif
      end
`ifdef RF_ARB_STARVE_EN
      FORCE: begin
        if (!wb_en) begin
          drain         = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = 3'd0;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
`ifdef RF_ARB_STARVE_EN
      wait_cnt <= 3'd0;
`endif
    end else begin
      state <= state_next;
`ifdef RF_ARB_STARVE_EN
      wait_cnt <= wait_cnt_next;
`endif
    end
  end

`ifdef RF_ARB_STARVE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall <= 1'b0;
    else        stall <= (state_next == FORCE);
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_data  <= 32'd0;
      buf_rd   <= 5'd0;
      buf_data <= 32'd0;
    end else begin
      rf_we <= 1'b0;
      // drain only fires when wb_en is low, so the two sources never collide.
      if (wb_en && (wb_rd != 5'd0)) begin
        rf_we   <= 1'b1;
        rf_rd   <= wb_rd;
        rf_data <= wb_data;
      end else if (drain) begin
        rf_we   <= 1'b1;
        rf_rd   <= buf_rd;
        rf_data <= buf_data;
      end
      if (load) begin
        buf_rd   <= io_rd;
        buf_data <= io_data;
      end else if (drain) begin
        buf_rd   <= 5'd0;
        buf_data <= 32'd0;
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive cycles a pending I/O write may lose to writeback before forced drain (legal 1..7).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 wb_en  input  1  pipeline writeback write request, highest priority.
REQ-005 wb_rd  input  5  writeback destination register.
REQ-006 wb_data  input  32  writeback data.
REQ-007 io_req  input  1  I/O requester (game controller/input logic) write request; held until acked.
REQ-008 io_rd  input  5  I/O destination register.
REQ-009 io_data  input  32  I/O write data.
REQ-010 io_ack  output  1  combinational; handshake completes on the rising edge where io_req and io_ack are both 1.
REQ-011 io_pending  output  1  a buffered I/O write awaits the register-file port.
REQ-012 stall  output  1  registered; pipeline SHALL hold wb_en low in every cycle stall=1.
REQ-013 rf_we  output  1  registered register-file write enable.
REQ-014 rf_rd  output  5  registered register-file write address.
REQ-015 rf_data  output  32  registered register-file write data.

Function
REQ-016 States: IDLE (buffer empty), PEND (buffer full), FORCE (buffer full, starvation drain); io_pending=1 in PEND and FORCE.
REQ-017 io_ack = io_req when state is IDLE, else 0.
REQ-018 IDLE, accepted io_req with io_rd!=0: load buffer {io_rd, io_data}, clear wait counter, go to PEND.
REQ-019 IDLE, accepted io_req with io_rd==0: discard write, stay IDLE, no rf_we.
REQ-020 Each edge: wb_en=1 and wb_rd!=0 -> rf_we=1, rf_rd=wb_rd, rf_data=wb_data (latency 1 cycle).
REQ-021 PEND, edge with wb_en=0: rf_we=1 with buffered rd/data, clear buffer and counter, go to IDLE.
REQ-022 PEND, edge with wb_en=1: writeback wins, counter increments; counter reaching STARVE_LIMIT -> go to FORCE.
REQ-023 wb_en=1 with wb_rd==0 still counts as a lost cycle (port considered claimed) and produces rf_we=0.
REQ-024 FORCE: stall=1; edge with wb_en=0 drains buffer as REQ-021 and returns to IDLE with stall=0 next cycle.
REQ-025 FORCE with wb_en=1 (protocol violation): writeback still wins, stay in FORCE, counter saturates.
REQ-026 No edge produces rf_we without a write: otherwise rf_we=0, rf_rd and rf_data hold last value.
REQ-027 Best-case I/O latency: acked at edge E0, rf_we=1 after E1; max I/O throughput one write per 2 cycles.
REQ-028 Wait counter is 3 bits and never wraps.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, buffer cleared, counter 0, rf_we 0, rf_rd 0, rf_data 0, stall 0; io_ack follows io_req combinationally once reset releases.
REQ-030 Reset asserted in PEND or FORCE drops the buffered write; no rf_we issued for it after release.

Configuration
REQ-031 Macro RF_ARB_STARVE_EN defined: FORCE state, wait counter and stall behave per REQ-022..REQ-025.
REQ-032 RF_ARB_STARVE_EN undefined: no FORCE state or counter, stall tied 0, PEND waits indefinitely for a wb_en=0 cycle.

Verification
REQ-033 Reset release, wb_en=1 wb_rd=3 wb_data=32'h0000DEAD one cycle -> next cycle rf_we=1 rf_rd=3 rf_data=32'h0000DEAD, then rf_we=0.
REQ-034 IDLE, io_req rd=5 data=32'h00000002, wb_en=0 -> io_ack=1 same cycle, io_pending=1 next, rf_we=1 rf_rd=5 following cycle, io_pending=0.
REQ-035 Buffer holds rd=7, wb_en=1 continuously (STARVE_LIMIT=4, RF_ARB_STARVE_EN defined) -> 4 writeback writes, then stall=1; drop wb_en -> rf_we=1 rf_rd=7, stall=0 next cycle.
REQ-036 Same as REQ-035 without RF_ARB_STARVE_EN for 20 cycles -> stall=0 throughout, io_pending=1, io_ack=0 for second requester.
REQ-037 io_req rd=0 and wb_en rd=0 -> io_ack=1, rf_we=0 for every cycle, state stays IDLE.
REQ-038 Buffer full rd=9, assert reset=0 mid-PEND, release -> io_pending=0, rf_we=0, no write to r9 ever issued.
